// File: rtl/rs232_cmd_pkg.sv
// rs232_cmd_pkg: shared FSM encoding, error codes and default sync byte for the command parser.
// GET_CHK exists only when RS232_CMD_CHECKSUM_EN is defined.
package rs232_cmd_pkg;
    typedef enum logic [2:0] {
        HUNT,
        GET_ID,
        GET_LEN,
        GET_PAYLOAD,
`ifdef RS232_CMD_CHECKSUM_EN
        GET_CHK,
`endif
        HOLD
    } state_t;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/rs232_gap_timer.sv
// rs232_gap_timer: counts clock_4x cycles since the last received byte; expired is high on the
// cycle whose edge would bring the count to TIMEOUT_CYCLES, so the error lands exactly on it.
module rs232_gap_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic clock_4x,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;
    always_ff @(posedge clock_4x or posedge reset)
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 16'd1;
    assign expired = enable && !clear && count == TIMEOUT_CYCLES - 16'd1;
endmodule

// File: rtl/rs232_command_parser.sv
// rs232_command_parser: frames SYNC/ID/LEN/payload byte streams into commands with a ready/valid hand-off.
// Define RS232_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module rs232_command_parser
    import rs232_cmd_pkg::*;
#(
    parameter int MAX_PAYLOAD = 12,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic                     clock_4x,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic [7:0]               cmd_id,
    output logic [3:0]               cmd_len,
    output logic [MAX_PAYLOAD*8-1:0] cmd_payload,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     cmd_error,
    output logic [1:0]               error_code,
    output logic                     overrun
);
    state_t state;
    logic [7:0] pay [MAX_PAYLOAD];
    logic [3:0] idx;
    logic expired;
    logic gap_enable;
    logic gap_clear;
    logic sync_seen;
`ifdef RS232_CMD_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = GET_CHK;
    localparam logic END_VALID = 1'b0;
    logic [7:0] chk;
    // GET_ID reseeds the running XOR, so stray updates in other states are harmless
    always_ff @(posedge clock_4x or posedge reset)
        if (reset)
            chk <= '0;
        else if (rx_valid)
            chk <= (state == GET_ID) ? rx_byte : chk ^ rx_byte;
`else
    localparam state_t AFTER_PAYLOAD = HOLD;
    localparam logic END_VALID = 1'b1;
`endif
    assign gap_enable = state != HUNT && state != HOLD;
    assign gap_clear = rx_valid || !gap_enable;
    assign sync_seen = rx_valid && rx_byte == SYNC_BYTE;
    rs232_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
        .clock_4x(clock_4x),
        .reset(reset),
        .clear(gap_clear),
        .enable(gap_enable),
        .expired(expired)
    );
    for (genvar i = 0; i < MAX_PAYLOAD; i++) begin : g_pack
        assign cmd_payload[MAX_PAYLOAD*8-1-8*i -: 8] = pay[i];
    end
    always_ff @(posedge clock_4x or posedge reset)
        if (reset) begin
            state <= HUNT;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            overrun <= 1'b0;
            cmd_id <= '0;
            cmd_len <= '0;
            error_code <= '0;
            idx <= '0;
            pay <= '{default: '0};
        end else begin
            cmd_error <= 1'b0;
            if (expired) begin
                cmd_error <= 1'b1;
                error_code <= ERR_TIMEOUT;
                state <= HUNT;
            end else begin
                case (state)
                    HUNT: if (sync_seen) begin
                        state <= GET_ID;
                        pay <= '{default: '0};
                    end
                    GET_ID: if (rx_valid) begin
                        cmd_id <= rx_byte;
                        state <= GET_LEN;
                    end
                    GET_LEN: if (rx_valid) begin
                        cmd_len <= rx_byte[3:0];
                        idx <= '0;
                        if (rx_byte > 8'(MAX_PAYLOAD)) begin
                            cmd_error <= 1'b1;
                            error_code <= ERR_LEN;
                            state <= HUNT;
                        end else if (rx_byte == 8'd0) begin
                            state <= AFTER_PAYLOAD;
                            cmd_valid <= END_VALID;
                        end else
                            state <= GET_PAYLOAD;
                    end
                    GET_PAYLOAD: if (rx_valid) begin
                        pay[idx] <= rx_byte;
                        idx <= idx + 4'd1;
                        if (idx + 4'd1 == cmd_len) begin
                            state <= AFTER_PAYLOAD;
                            cmd_valid <= END_VALID;
                        end
                    end
`ifdef RS232_CMD_CHECKSUM_EN
                    GET_CHK: if (rx_valid) begin
                        if (rx_byte == chk) begin
                            state <= HOLD;
                            cmd_valid <= 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                            error_code <= ERR_CHK;
                            state <= HUNT;
                        end
                    end
`endif
                    // a byte arriving with acceptance is treated as the first HUNT byte
                    HOLD: if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        overrun <= 1'b0;
                        state <= sync_seen ? GET_ID : HUNT;
                        if (sync_seen)
                            pay <= '{default: '0};
                    end else if (rx_valid)
                        overrun <= 1'b1;
                    default: state <= HUNT;
                endcase
            end
        end
endmodule

// File: tb/tb_rs232_command_parser.sv
// tb_rs232_command_parser: byte-level reference model plus directed and random frames for the parser.
module tb_rs232_command_parser;
    localparam int MAXP = 12;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TO = 2000;
`ifdef RS232_CMD_CHECKSUM_EN
    localparam int CHK_ON = 1;
`else
    localparam int CHK_ON = 0;
`endif
    logic clock_4x = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_byte = '0;
    logic rx_valid = 1'b0;
    logic cmd_ready = 1'b1;
    logic [7:0] cmd_id;
    logic [3:0] cmd_len;
    logic [MAXP*8-1:0] cmd_payload;
    logic cmd_valid;
    logic cmd_error;
    logic [1:0] error_code;
    logic overrun;
    int total = 0;
    int bad = 0;
    bit rand_ready = 1'b0;

    rs232_command_parser #(
        .MAX_PAYLOAD(MAXP),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(16'(TO))
    ) dut (
        .clock_4x(clock_4x),
        .reset(reset),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .cmd_id(cmd_id),
        .cmd_len(cmd_len),
        .cmd_payload(cmd_payload),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_error(cmd_error),
        .error_code(error_code),
        .overrun(overrun)
    );

    initial forever #5 clock_4x = ~clock_4x;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: bytes of the frame in flight, idle gap length, and the expected outputs
    bit in_frame = 0;
    bit holding = 0;
    bit id_known = 1;
    logic [7:0] fb[$];
    int gap = 0;
    logic exp_valid = 0;
    logic exp_err = 0;
    logic exp_ovr = 0;
    logic [1:0] exp_code = 0;
    logic [7:0] exp_id = 0;
    logic [3:0] exp_len = 0;
    logic [MAXP*8-1:0] exp_pay = 0;

    task automatic m_hunt(input logic [7:0] b);
        if (b == SYNC) begin
            in_frame = 1;
            fb.delete();
            gap = 0;
            id_known = 0;
        end
    endtask

    task automatic m_err(input logic [1:0] c);
        exp_err = 1;
        exp_code = c;
        in_frame = 0;
    endtask

    task automatic m_frame();
        int n = fb.size();
        int need;
        logic [7:0] x = 8'h00;
        if (n < 2) return;
        if (int'(fb[1]) > MAXP) begin
            m_err(2'd1);
            return;
        end
        need = 2 + int'(fb[1]) + CHK_ON;
        if (n < need) return;
        for (int i = 0; i < 2 + int'(fb[1]); i++) x ^= fb[i];
        if (CHK_ON == 1 && fb[n-1] != x) begin
            m_err(2'd2);
            return;
        end
        in_frame = 0;
        holding = 1;
        exp_valid = 1;
        exp_id = fb[0];
        exp_len = fb[1][3:0];
        exp_pay = '0;
        for (int i = 0; i < int'(fb[1]); i++) exp_pay[(MAXP-1-i)*8 +: 8] = fb[2+i];
        id_known = 1;
    endtask

    always @(posedge clock_4x or posedge reset) begin
        if (reset) begin
            in_frame = 0; holding = 0; id_known = 1; gap = 0; fb.delete();
            exp_valid = 0; exp_err = 0; exp_ovr = 0; exp_code = 0;
            exp_id = 0; exp_len = 0; exp_pay = 0;
        end else begin
            exp_err = 0;
            if (holding) begin
                if (cmd_ready) begin
                    holding = 0;
                    exp_valid = 0;
                    exp_ovr = 0;
                    if (rx_valid) m_hunt(rx_byte);
                end else if (rx_valid)
                    exp_ovr = 1;
            end else if (!in_frame) begin
                if (rx_valid) m_hunt(rx_byte);
            end else if (rx_valid) begin
                gap = 0;
                fb.push_back(rx_byte);
                m_frame();
            end else begin
                gap++;
                if (gap == TO) m_err(2'd3);
            end
        end
    end

    always @(negedge clock_4x) begin
        check("cmd_valid", cmd_valid, exp_valid);
        check("cmd_error", cmd_error, exp_err);
        check("overrun", overrun, exp_ovr);
        check("error_code", error_code, exp_code);
        if (id_known) begin
            check("cmd_id", cmd_id, exp_id);
            check("cmd_len", cmd_len, exp_len);
            check("cmd_payload", cmd_payload, exp_pay);
        end
    end

    task automatic cyc(input bit v, input logic [7:0] b);
        @(posedge clock_4x);
        #1;
        rx_valid = v;
        rx_byte = b;
        if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom));
    endtask

    initial begin
        int at_k;
        logic [1:0] at_code;
        logic [7:0] x;
        int len;
        repeat (3) @(posedge clock_4x);
        @(negedge clock_4x);
        check("reset cmd_valid", cmd_valid, 0);
        check("reset cmd_id", cmd_id, 0);
        check("reset cmd_len", cmd_len, 0);
        check("reset payload", cmd_payload, 0);
        check("reset error_code", error_code, 0);
        check("reset overrun", overrun, 0);
        @(posedge clock_4x);
        #1 reset = 0;
        idle(2);

        // two-byte frame; its XOR checksum is 8'h61
        send(SYNC); send(8'h10); send(8'h02); send(8'hDE); send(8'hAD);
`ifdef RS232_CMD_CHECKSUM_EN
        send(8'h10 ^ 8'h02 ^ 8'hDE ^ 8'hAD);
`endif
        @(negedge clock_4x);
        check("t1 not early", cmd_valid, 0);
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("t1 valid", cmd_valid, 1);
        check("t1 id", cmd_id, 8'h10);
        check("t1 len", cmd_len, 4'd2);
        check("t1 payload", cmd_payload, {8'hDE, 8'hAD, 80'h0});
        check("t1 model payload", exp_pay, {8'hDE, 8'hAD, 80'h0});
        idle(2);

        send(SYNC); send(8'h20); send(8'h0F);
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("len err pulse", cmd_error, 1);
        check("len err code", error_code, 2'd1);
        send(SYNC); send(8'h33); send(8'h01); send(8'h7E);
`ifdef RS232_CMD_CHECKSUM_EN
        send(8'h33 ^ 8'h01 ^ 8'h7E);
`endif
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("after len err valid", cmd_valid, 1);
        check("after len err id", cmd_id, 8'h33);
        check("after len err payload", cmd_payload, {8'h7E, 88'h0});
        idle(2);

`ifdef RS232_CMD_CHECKSUM_EN
        send(SYNC); send(8'h10); send(8'h01); send(8'h55); send(8'h00);
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("chk err pulse", cmd_error, 1);
        check("chk err code", error_code, 2'd2);
        check("chk err model code", exp_code, 2'd2);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 8'h00);
            @(negedge clock_4x);
            check("chk err no valid", cmd_valid, 0);
        end
`endif

        send(SYNC); send(8'h10);
        at_k = -1;
        at_code = 0;
        for (int k = 0; k <= TO + 1; k++) begin
            cyc(1'b0, 8'h00);
            @(negedge clock_4x);
            if (cmd_error) begin
                at_k = k;
                at_code = error_code;
            end
        end
        check("timeout cycle", at_k, TO);
        check("timeout code", at_code, 2'd3);

        cmd_ready = 0;
        send(SYNC); send(8'h44); send(8'h02); send(8'h12); send(8'h34);
`ifdef RS232_CMD_CHECKSUM_EN
        send(8'h44 ^ 8'h02 ^ 8'h12 ^ 8'h34);
`endif
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("hold valid", cmd_valid, 1);
        idle(2);
        send(8'h33);
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("overrun set", overrun, 1);
        check("overrun valid kept", cmd_valid, 1);
        check("overrun id kept", cmd_id, 8'h44);
        check("overrun payload kept", cmd_payload, {8'h12, 8'h34, 80'h0});
        cyc(1'b1, SYNC);
        cmd_ready = 1;
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("accept drops valid", cmd_valid, 0);
        check("accept clears overrun", overrun, 0);
        send(8'h55); send(8'h01); send(8'h9A);
`ifdef RS232_CMD_CHECKSUM_EN
        send(8'h55 ^ 8'h01 ^ 8'h9A);
`endif
        cyc(1'b0, 8'h00);
        @(negedge clock_4x);
        check("sync on accept valid", cmd_valid, 1);
        check("sync on accept id", cmd_id, 8'h55);
        check("sync on accept payload", cmd_payload, {8'h9A, 88'h0});
        idle(2);

        send(SYNC); send(8'h10); send(8'h03); send(8'h11); send(8'h22);
        @(posedge clock_4x);
        #1;
        reset = 1;
        rx_valid = 0;
        @(negedge clock_4x);
        check("mid reset valid", cmd_valid, 0);
        check("mid reset error", cmd_error, 0);
        check("mid reset id", cmd_id, 0);
        check("mid reset len", cmd_len, 0);
        check("mid reset payload", cmd_payload, 0);
        check("mid reset code", error_code, 0);
        check("mid reset overrun", overrun, 0);
        @(posedge clock_4x);
        #1 reset = 0;
        idle(6);

        rand_ready = 1;
        for (int f = 0; f < 160; f++) begin
            idle($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) send(8'($urandom));
            send(SYNC);
            x = 8'($urandom);
            send(x);
            if (f == 60 || f == 120) begin
                idle(TO + 2);
                continue;
            end
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(MAXP + 1, 255) : $urandom_range(0, MAXP);
            idle($urandom_range(0, 2));
            send(8'(len));
            x ^= 8'(len);
            if (len <= MAXP) begin
                for (int i = 0; i < len; i++) begin
                    logic [7:0] b = 8'($urandom);
                    x ^= b;
                    idle($urandom_range(0, 2));
                    send(b);
                end
`ifdef RS232_CMD_CHECKSUM_EN
                idle($urandom_range(0, 2));
                send(($urandom_range(0, 7) == 0) ? ~x : x);
`endif
            end
            idle($urandom_range(0, 4));
        end
        rand_ready = 0;
        cmd_ready = 1;
        idle(6);
        @(negedge clock_4x);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
